dec_unbinder_seq: RTL

Sequential unbinder for the sparse HDC datapath, and the inverse of the encoder binder stage. The encoder rotates each feature's level hypervector left by a per-feature constant. This block accepts those bound hypervectors one feature per beat, rotates each right by the same constant, and emits the recovered level hypervector with its feature index. It sits on the decode/readback path between bound-HV storage and the level-memory comparator.

---
 rtl/hdc_pkg.sv | 28 ++
 rtl/dec_unbinder.sv | 24 ++
 rtl/dec_unbinder_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hdc_pkg.sv
// +--------------------------------------------------------------------------+
// | hdc_pkg: shared HDC constants, encoder shift table, decoder FSM state. rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

package hdc_pkg;

   localparam int HV_DIM          = 1024;
   localparam int FEATURES_PER_CC = 3;
   localparam int ACTIVE_BITS     = 32;

   // Per-feature rotate amounts; the encoder binder uses the same table.
   localparam int NUM_SHIFTS = 8;
   localparam int SHIFTS [NUM_SHIFTS] = '{3, 5, 0, 9, 14, 2, 7, 11};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } dec_state_t;

   function automatic int shift_at(input int idx);
      return (idx >= 0 && idx < NUM_SHIFTS) ? SHIFTS[idx] : 0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dec_unbinder.sv
// +--------------------------------------------------------------------------+
// | dec_unbinder: combinational right-rotate by a runtime amount.     rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module dec_unbinder
   import hdc_pkg::*;
#(
   parameter int HV_DIM = hdc_pkg::HV_DIM,
   parameter int SH_W   = (HV_DIM > 1) ? $clog2(HV_DIM) : 1
) (
   input  logic [HV_DIM-1:0] din,
   input  logic [SH_W-1:0]   shift,
   output logic [HV_DIM-1:0] dout
);

   // Shifting the doubled vector gives dout[j] = din[(j+shift) mod HV_DIM].
   always_comb begin
      dout = HV_DIM'({din, din} >> shift);
   end

endmodule

`default_nettype wire

// File: rtl/dec_unbinder_seq.sv
// +--------------------------------------------------------------------------+
// | dec_unbinder_seq: per-feature sequential unbinder, optional density check |
// | enabled by DEC_UNBINDER_DENSITY_CHECK_EN.                         rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module dec_unbinder_seq #(
   parameter int HV_DIM          = hdc_pkg::HV_DIM,
   parameter int FEATURES_PER_CC = hdc_pkg::FEATURES_PER_CC,
   parameter int BASE_FEATURE    = 0
`ifdef DEC_UNBINDER_DENSITY_CHECK_EN
   ,
   parameter int ACTIVE_BITS     = hdc_pkg::ACTIVE_BITS
`endif
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start_decoding,
   input  logic                               en,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [HV_DIM-1:0]                  bound_hv,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [HV_DIM-1:0]                  level_hv,
   output logic [$clog2(FEATURES_PER_CC)-1:0] feature_idx,
   output logic                               done
`ifdef DEC_UNBINDER_DENSITY_CHECK_EN
   ,
   output logic                               density_err
`endif
);

   import hdc_pkg::*;

   localparam int IDX_W = $clog2(FEATURES_PER_CC);
   localparam int CNT_W = $clog2(FEATURES_PER_CC + 1);
   localparam int SH_W  = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FEATURES_PER_CC);

   dec_state_t        state;
   dec_state_t        state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [SH_W-1:0]   shift;
   logic [HV_DIM-1:0] rotated;
   logic              in_hs;
   logic              out_hs;
   logic              start_ok;

   always_comb begin
      shift = SH_W'(shift_at(BASE_FEATURE + int'(cnt)) % HV_DIM);
   end

   dec_unbinder #(
      .HV_DIM (HV_DIM),
      .SH_W   (SH_W)
   ) u_rot (
      .din   (bound_hv),
      .shift (shift),
      .dout  (rotated)
   );

`ifdef DEC_UNBINDER_DENSITY_CHECK_EN
   localparam int PC_W = $clog2(HV_DIM + 1);
   logic [PC_W-1:0] popcnt;
   logic            dens_bad;

   always_comb begin
      popcnt = '0;
      for (int i = 0; i < HV_DIM; i++) begin
         popcnt = popcnt + PC_W'(rotated[i]);
      end
      dens_bad = (popcnt != PC_W'(ACTIVE_BITS));
   end
`endif

   // cnt == LAST_CNT means every feature of the pass has been accepted.
   always_comb begin
      start_ok = (state == ST_IDLE) && start_decoding && en;
      in_ready = (state == ST_RUN) && (cnt != LAST_CNT) && en && (!out_valid || out_ready);
      in_hs    = in_valid && in_ready;
      out_hs   = out_valid && out_ready;
      done     = (state == ST_DONE);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start_ok) state_nxt = ST_RUN;
         ST_RUN:  if ((cnt == LAST_CNT) && out_hs) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         out_valid   <= 1'b0;
         level_hv    <= '0;
         feature_idx <= '0;
`ifdef DEC_UNBINDER_DENSITY_CHECK_EN
         density_err <= 1'b0;
`endif
      end else begin
         if (start_ok) begin
            cnt <= '0;
         end else if (in_hs) begin
            cnt <= cnt + CNT_W'(1);
         end

         if (in_hs) begin
            level_hv    <= rotated;
            feature_idx <= cnt[IDX_W-1:0];
            out_valid   <= 1'b1;
`ifdef DEC_UNBINDER_DENSITY_CHECK_EN
            density_err <= dens_bad;
`endif
         end else if (out_hs) begin
            out_valid   <= 1'b0;
`ifdef DEC_UNBINDER_DENSITY_CHECK_EN
            density_err <= 1'b0;
`endif
         end
      end
   end

endmodule

`default_nettype wire
